debug_dump_tx: RTL
==================

Name: debug_dump_tx

Overview:
Debug-unit transmit sequencer inside TOP_MIPS. On a start pulse from the debug control FSM (after program load or after each step), it serialises a snapshot of the CPU state to the UART transmitter as 260 bytes:
- PC (4 bytes)
- registers 0..31 (128 bytes)
- data memory words 0..31 (128 bytes)

Every word goes out LSB first. It sits between the register file / data memory debug read ports and the UART TX.

Parameters:
DATA_WIDTH, 32, CPU word width; must be a multiple of DATA_WIDTH_UART
DATA_WIDTH_UART, 8, UART byte width
N_REGS, 32, register words dumped
N_MEM, 32, data-memory words dumped
ADDR_WIDTH, 5, read-address width for register file and memory debug ports

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse that begins a dump
i_pc  in  DATA_WIDTH  current PC
o_reg_addr  out  ADDR_WIDTH  register-file debug read address
i_reg_data  in  DATA_WIDTH  register-file debug read data, valid 1 cycle after address
o_mem_addr  out  ADDR_WIDTH  data-memory debug read address
i_mem_data  in  DATA_WIDTH  data-memory debug read data, valid 1 cycle after address
o_tx_result  out  DATA_WIDTH_UART  byte to UART TX
o_tx_signal  out  1  one-cycle send request to UART TX
i_tx_done  in  1  one-cycle pulse: UART finished the current byte
o_busy  out  1  high from the cycle after i_start until dump end
o_done  out  1  one-cycle pulse when the last byte's i_tx_done is seen

Behaviour:
- Reset (i_reset=0, async): state IDLE; all outputs 0; word register, byte index and word index all 0.
- FSM states: IDLE, LOAD_PC, ADDR, WAIT_RD, LOAD_WORD, SEND, WAIT_TX, NEXT, FINISH.
- IDLE
  - i_start=1 -> LOAD_PC; o_busy=1 next cycle.
  - i_start while o_busy=1 is ignored.
- LOAD_PC: shift = i_pc (snapshot; later PC changes are irrelevant); section=PC -> SEND.
- ADDR: drive o_reg_addr or o_mem_addr = word index (the other address holds 0) -> WAIT_RD.
- WAIT_RD: one cycle for the synchronous read -> LOAD_WORD.
- LOAD_WORD: shift = i_reg_data or i_mem_data per section -> SEND.
- SEND: o_tx_result = shift[7:0]; o_tx_signal=1 for exactly this cycle -> WAIT_TX.
- WAIT_TX
  - Hold o_tx_result stable.
  - On i_tx_done: shift >>= 8, byte index += 1.
  - byte index reaching DATA_WIDTH/DATA_WIDTH_UART (4) -> NEXT; otherwise -> SEND.
  - An i_tx_done in any other state is ignored.
- NEXT: byte index = 0, then:
  - section PC -> section REG, word 0 -> ADDR.
  - REG, word index < N_REGS-1 -> word index +1 -> ADDR.
  - REG last -> section MEM, word 0 -> ADDR.
  - MEM, word index < N_MEM-1 -> +1 -> ADDR.
  - MEM last -> FINISH.
- FINISH: o_done=1 for one cycle, o_busy=0 -> IDLE.
- Byte count per dump: 4*(1+N_REGS+N_MEM) = 260 with defaults.
- Latency: i_start to first o_tx_signal is 2 cycles (LOAD_PC, SEND).
- Word index width is ADDR_WIDTH+1 so the compare with N_REGS/N_MEM does not wrap. Addresses are truncated to ADDR_WIDTH.
- Reset asserted mid-dump: immediate abort to IDLE; no o_done; the next i_start restarts from the PC.
- No timeout: the block waits in WAIT_TX indefinitely for i_tx_done.

Decomposition:
- Shared package (mips_debug_pkg): section encoding (SEC_PC, SEC_REG, SEC_MEM), FSM state constants, BYTES_PER_WORD = DATA_WIDTH/DATA_WIDTH_UART, dump-length constant.
- One natural sub-module: debug_word_serializer (shift register + byte counter + SEND/WAIT_TX handshake). The parent FSM sequences sections and read addresses.

Test Plan:
- i_pc=0x0000_0010, regs r[k]=k, mem m[k]=0x100+k, i_start pulse, UART model pulses i_tx_done 5 cycles after each o_tx_signal -> exactly 260 o_tx_signal pulses.
  - First 4 bytes 0x10,0x00,0x00,0x00.
  - Bytes 4..7 = 0x00 x4; bytes 8..11 = 0x01,0,0,0.
  - Last word bytes 0x1F,0x01,0x00,0x00.
  - o_done once after the last i_tx_done.
- Change i_pc to 0xDEAD_BEEF one cycle after i_start -> dumped PC bytes still 0x10,0,0,0.
- Second i_start pulse during the dump -> ignored; total still 260 bytes; a single o_done.
- i_reset=0 after byte 70 -> all outputs 0 immediately, no o_done; a new i_start gives a full 260-byte dump starting with the PC.
- Spurious i_tx_done in IDLE and in WAIT_RD -> no byte-index change; byte stream identical to the first scenario.
- i_tx_done delayed 2000 cycles on one byte -> o_tx_result stable and no extra o_tx_signal throughout the wait.

Source files
------------

// File: rtl/mips_debug_pkg.sv
// Shared types and constants for the MIPS debug-unit dump path:
// section and FSM encodings plus the default geometry of one snapshot.
package mips_debug_pkg;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_DATA_WIDTH_UART = 8;
    localparam int DEF_N_REGS          = 32;
    localparam int DEF_N_MEM           = 32;
    localparam int DEF_ADDR_WIDTH      = 5;

    typedef enum logic [1:0] {
        SEC_PC,
        SEC_REG,
        SEC_MEM
    } section_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_PC,
        ST_ADDR,
        ST_WAIT_RD,
        ST_LOAD_WORD,
        ST_SEND,
        ST_WAIT_TX,
        ST_NEXT,
        ST_FINISH
    } state_e;

    function automatic int bytes_per_word(input int data_width, input int uart_width);
        return data_width / uart_width;
    endfunction

    function automatic int dump_bytes(input int data_width, input int uart_width,
                                      input int n_regs, input int n_mem);
        return bytes_per_word(data_width, uart_width) * (1 + n_regs + n_mem);
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(DEF_DATA_WIDTH, DEF_DATA_WIDTH_UART);
    localparam int DUMP_BYTES     = dump_bytes(DEF_DATA_WIDTH, DEF_DATA_WIDTH_UART,
                                               DEF_N_REGS, DEF_N_MEM);

endpackage

// File: rtl/debug_dump_tx_if.sv
// Debug read ports (register file, data memory) and UART TX handshake
// seen by the dump sequencer; master is the sequencer side.
interface debug_dump_tx_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int ADDR_WIDTH      = 5
);
    logic [ADDR_WIDTH-1:0]      o_reg_addr;
    logic [DATA_WIDTH-1:0]      i_reg_data;
    logic [ADDR_WIDTH-1:0]      o_mem_addr;
    logic [DATA_WIDTH-1:0]      i_mem_data;
    logic [DATA_WIDTH_UART-1:0] o_tx_result;
    logic                       o_tx_signal;
    logic                       i_tx_done;

    modport master (
        output o_reg_addr, o_mem_addr, o_tx_result, o_tx_signal,
        input  i_reg_data, i_mem_data, i_tx_done
    );

    modport slave (
        input  o_reg_addr, o_mem_addr, o_tx_result, o_tx_signal,
        output i_reg_data, i_mem_data, i_tx_done
    );
endinterface

// File: rtl/debug_word_serializer.sv
// Shift register and byte counter that emit one CPU word to the UART,
// least-significant byte first; the parent FSM decides when to send/wait.
module debug_word_serializer
    import mips_debug_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int UART_WIDTH = DEF_DATA_WIDTH_UART
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  send,
    input  logic                  waiting,
    input  logic                  clear,
    input  logic                  tx_done,
    output logic [UART_WIDTH-1:0] tx_result,
    output logic                  tx_signal,
    output logic                  accept,
    output logic                  last_byte
);
    localparam int BPW = bytes_per_word(DATA_WIDTH, UART_WIDTH);
    localparam int CW  = $clog2(BPW + 1);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CW-1:0]         byte_idx_q;

    // A done pulse only counts while the UART is actually being waited on.
    assign accept    = waiting & tx_done;
    assign last_byte = (byte_idx_q == CW'(BPW - 1));
    assign tx_result = shift_q[UART_WIDTH-1:0];
    assign tx_signal = send;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            byte_idx_q <= '0;
        end else begin
            if (load) begin
                shift_q <= load_data;
            end else if (accept) begin
                shift_q    <= shift_q >> UART_WIDTH;
                byte_idx_q <= byte_idx_q + CW'(1);
            end
            if (clear) begin
                byte_idx_q <= '0;
            end
        end
    end

endmodule

// File: rtl/debug_dump_tx.sv
// Debug dump sequencer: on i_start streams PC, register file and data
// memory to the UART TX as bytes, walking the debug read ports in order.
module debug_dump_tx
    import mips_debug_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DATA_WIDTH_UART = DEF_DATA_WIDTH_UART,
    parameter int N_REGS          = DEF_N_REGS,
    parameter int N_MEM           = DEF_N_MEM,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic                  o_busy,
    output logic                  o_done,
    debug_dump_tx_if.master       bus
);
    localparam int WIDX_W = ADDR_WIDTH + 1;
    localparam logic [WIDX_W-1:0] LAST_REG = WIDX_W'(N_REGS - 1);
    localparam logic [WIDX_W-1:0] LAST_MEM = WIDX_W'(N_MEM - 1);

    state_e              state_q, state_d;
    section_e            section_q;
    logic [WIDX_W-1:0]   word_idx_q;
    logic                start_accept;
    logic                addr_phase;
    logic                load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                accept;
    logic                last_byte;

    assign start_accept = (state_q == ST_IDLE) && i_start;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next state defaults to the current one before the case so no
    // path leaves state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (i_start) state_d = ST_LOAD_PC;
            ST_LOAD_PC:   state_d = ST_SEND;
            ST_ADDR:      state_d = ST_WAIT_RD;
            ST_WAIT_RD:   state_d = ST_LOAD_WORD;
            ST_LOAD_WORD: state_d = ST_SEND;
            ST_SEND:      state_d = ST_WAIT_TX;
            ST_WAIT_TX:   if (accept) state_d = last_byte ? ST_NEXT : ST_SEND;
            ST_NEXT: begin
                if (section_q == SEC_MEM && word_idx_q == LAST_MEM) state_d = ST_FINISH;
                else                                                state_d = ST_ADDR;
            end
            ST_FINISH:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            section_q  <= SEC_PC;
            word_idx_q <= '0;
        end else if (start_accept) begin
            section_q  <= SEC_PC;
            word_idx_q <= '0;
        end else if (state_q == ST_NEXT) begin
            case (section_q)
                SEC_PC: begin
                    section_q  <= SEC_REG;
                    word_idx_q <= '0;
                end
                SEC_REG: begin
                    if (word_idx_q == LAST_REG) begin
                        section_q  <= SEC_MEM;
                        word_idx_q <= '0;
                    end else begin
                        word_idx_q <= word_idx_q + WIDX_W'(1);
                    end
                end
                SEC_MEM: begin
                    if (word_idx_q != LAST_MEM) word_idx_q <= word_idx_q + WIDX_W'(1);
                end
                default: section_q <= SEC_PC;
            endcase
        end
    end

    // Address is held until the word is captured so a registered-read
    // port returns the addressed word during LOAD_WORD.
    assign addr_phase = (state_q == ST_ADDR) || (state_q == ST_WAIT_RD) ||
                        (state_q == ST_LOAD_WORD);
    assign bus.o_reg_addr = (addr_phase && section_q == SEC_REG) ?
                            word_idx_q[ADDR_WIDTH-1:0] : '0;
    assign bus.o_mem_addr = (addr_phase && section_q == SEC_MEM) ?
                            word_idx_q[ADDR_WIDTH-1:0] : '0;

    // PC is captured on the start edge itself, so a PC change in the
    // following cycle cannot leak into the dump.
    assign load = start_accept || (state_q == ST_LOAD_WORD);

    always_comb begin
        load_data = i_pc;
        if (state_q != ST_IDLE) begin
            load_data = (section_q == SEC_MEM) ? bus.i_mem_data : bus.i_reg_data;
        end
    end

    debug_word_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .UART_WIDTH (DATA_WIDTH_UART)
    ) u_serializer (
        .clk       (i_clock),
        .rst_n     (i_reset),
        .load      (load),
        .load_data (load_data),
        .send      (state_q == ST_SEND),
        .waiting   (state_q == ST_WAIT_TX),
        .clear     (state_q == ST_NEXT),
        .tx_done   (bus.i_tx_done),
        .tx_result (bus.o_tx_result),
        .tx_signal (bus.o_tx_signal),
        .accept    (accept),
        .last_byte (last_byte)
    );

    assign o_busy = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign o_done = (state_q == ST_FINISH);

endmodule
